// File: rtl/qk_inst_sequencer.sv
// qk_inst_sequencer: drives the attention core's 19-bit instruction bus.
// It writes streamed Q/K vectors into qmem/kmem. It then runs the kernel
// load, execute, drain and output-FIFO-to-psum-memory writeback, and
// finally pulses done.
// Optional build macro PMEM_READBACK_EN adds a psum-memory readback phase
// (inst[1]) after writeback. Without it, inst[1] is never driven high.
module qk_inst_sequencer #(
  parameter int col       = 8,
  parameter int bw        = 8,
  parameter int pr        = 16,
  parameter int LOAD_GAP  = 4,
  parameter int DRAIN_CYC = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       q_len,
  input  logic [pr*bw-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [18:0]      inst,
  output logic [pr*bw-1:0] mem_in,
  output logic             busy,
  output logic             done
);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_Q, S_WR_K, S_LD_K, S_GAP, S_EXEC, S_DRAIN, S_OUT, S_RDBK, S_DONE
  } state_t;

  localparam logic [5:0] COL_W      = 6'(col);
  localparam logic [5:0] COL_LAST   = 6'(col - 1);
  localparam logic [5:0] GAP_LAST   = 6'(LOAD_GAP - 1);
  localparam logic [5:0] DRAIN_LAST = 6'(DRAIN_CYC - 1);

  state_t      state_r;
  logic [5:0]  cnt_r;
  logic [5:0]  q_len_r;
  logic [5:0]  cnt_m1_s;
  logic [5:0]  q_last_s;
  logic        accept_s;

  assign cnt_m1_s = cnt_r - 6'd1;
  assign q_last_s = q_len_r - 6'd1;
  assign accept_s = in_ready & in_valid;

  // Ready depends only on the write phase and how many beats have been taken.
  always_comb begin
    in_ready = 1'b0;
    case (state_r)
      S_WR_Q:  in_ready = (cnt_r < q_len_r);
      S_WR_K:  in_ready = (cnt_r < COL_W);
      default: in_ready = 1'b0;
    endcase
  end

  // Sequencer FSM: phase counter plus registered instruction and data outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_IDLE;
      cnt_r   <= 6'd0;
      q_len_r <= 6'd0;
      inst    <= 19'd0;
      mem_in  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      inst <= 19'd0;
      done <= 1'b0;
      case (state_r)
        S_IDLE: begin
          cnt_r <= 6'd0;
          if (start) begin
            if (q_len == 6'd0) begin
              done <= 1'b1;
            end else if (q_len <= 6'd32) begin
              q_len_r <= q_len;
              busy    <= 1'b1;
              state_r <= S_WR_Q;
            end
          end
        end
        S_WR_Q: begin
          if (accept_s) begin
            inst[4]     <= 1'b1;
            inst[17:13] <= cnt_r[4:0];
            mem_in      <= in_data;
            // The last Q beat hands over with a cleared count so it is not reused for K.
            if (cnt_r == q_last_s) begin
              cnt_r   <= 6'd0;
              state_r <= S_WR_K;
            end else begin
              cnt_r <= cnt_r + 6'd1;
            end
          end
        end
        S_WR_K: begin
          if (accept_s) begin
            inst[2]     <= 1'b1;
            inst[17:13] <= cnt_r[4:0];
            mem_in      <= in_data;
            if (cnt_r == COL_LAST) begin
              cnt_r   <= 6'd0;
              state_r <= S_LD_K;
            end else begin
              cnt_r <= cnt_r + 6'd1;
            end
          end
        end
        S_LD_K: begin
          inst[6] <= 1'b1;
          if (cnt_r < COL_W) begin
            inst[3]     <= 1'b1;
            inst[17:13] <= cnt_r[4:0];
          end
          if (cnt_r == COL_W) begin
            cnt_r   <= 6'd0;
            state_r <= S_GAP;
          end else begin
            cnt_r <= cnt_r + 6'd1;
          end
        end
        S_GAP: begin
          if (cnt_r == GAP_LAST) begin
            cnt_r   <= 6'd0;
            state_r <= S_EXEC;
          end else begin
            cnt_r <= cnt_r + 6'd1;
          end
        end
        S_EXEC: begin
          inst[7] <= 1'b1;
          if (cnt_r < q_len_r) begin
            inst[5]     <= 1'b1;
            inst[17:13] <= cnt_r[4:0];
          end
          if (cnt_r == q_len_r) begin
            cnt_r   <= 6'd0;
            state_r <= S_DRAIN;
          end else begin
            cnt_r <= cnt_r + 6'd1;
          end
        end
        S_DRAIN: begin
          if (cnt_r == DRAIN_LAST) begin
            cnt_r   <= 6'd0;
            state_r <= S_OUT;
          end else begin
            cnt_r <= cnt_r + 6'd1;
          end
        end
        S_OUT: begin
          // FIFO pops on cycles 0..q_len-1; each popped word lands in pmem one cycle later.
          if (cnt_r < q_len_r) begin
            inst[18] <= 1'b1;
          end
          if (cnt_r != 6'd0) begin
            inst[0]    <= 1'b1;
            inst[12:8] <= cnt_m1_s[4:0];
          end
          if (cnt_r == q_len_r) begin
            cnt_r <= 6'd0;
`ifdef PMEM_READBACK_EN
            state_r <= S_RDBK;
`else
            state_r <= S_DONE;
`endif
          end else begin
            cnt_r <= cnt_r + 6'd1;
          end
        end
`ifdef PMEM_READBACK_EN
        S_RDBK: begin
          inst[1]    <= 1'b1;
          inst[12:8] <= cnt_r[4:0];
          if (cnt_r == q_last_s) begin
            cnt_r   <= 6'd0;
            state_r <= S_DONE;
          end else begin
            cnt_r <= cnt_r + 6'd1;
          end
        end
`endif
        S_DONE: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          cnt_r   <= 6'd0;
          state_r <= S_IDLE;
        end
        default: begin
          cnt_r   <= 6'd0;
          busy    <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qk_inst_sequencer.sv
// Directed testbench for qk_inst_sequencer.
// Each job's per-cycle outputs are recorded. The recorded trace is then
// compared against the instruction timeline derived from q_len and the
// phase lengths.
module tb_qk_inst_sequencer;

  localparam int COL   = 8;
  localparam int GAP   = 4;
  localparam int DRAIN = 16;
  localparam int W     = 128;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [5:0]    q_len = 6'd0;
  logic [W-1:0]  in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [18:0]   inst;
  logic [W-1:0]  mem_in;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_err = 0;
  bit rec = 1'b0;

  logic [18:0]  inst_q[$];
  logic [W-1:0] mem_q[$];
  logic         done_q[$];
  logic         busy_q[$];

  qk_inst_sequencer #(.col(COL), .bw(8), .pr(16), .LOAD_GAP(GAP), .DRAIN_CYC(DRAIN)) dut (
    .clk(clk), .reset(reset), .start(start), .q_len(q_len),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .inst(inst), .mem_in(mem_in), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Trace recorder, sampled away from the active edge.
  always @(negedge clk) begin
    if (rec) begin
      inst_q.push_back(inst);
      mem_q.push_back(mem_in);
      done_q.push_back(done);
      busy_q.push_back(busy);
    end
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] beat_data(input int i);
    logic [7:0] b;
    b = 8'((i + 1) * 17);
    return {16{b}};
  endfunction

  // Walk a recorded job trace and compare it with the expected timeline for q.
  task automatic analyze(input int q);
    int nq = 0, nk = 0, nld = 0, nkr = 0, nex = 0, nexr = 0;
    int nof = 0, npw = 0, nrd = 0, ndone = 0;
    int last_ld = -1, first_ex = -1, last_ex = -1, first_of = -1, last_of = -1, done_i = -1;
    logic [18:0] w;
    for (int i = 0; i < inst_q.size(); i++) begin
      w = inst_q[i];
      if (w[4]) begin
        chk("qwr_addr", 128'(w[17:13]), 128'(nq));
        chk("qwr_data", mem_q[i], beat_data(nq));
        nq++;
      end
      if (w[2]) begin
        chk("kwr_addr", 128'(w[17:13]), 128'(nk));
        chk("kwr_data", mem_q[i], beat_data(q + nk));
        nk++;
      end
      if (w[6]) begin
        nld++;
        last_ld = i;
        if (w[3]) begin
          chk("ld_addr", 128'(w[17:13]), 128'(nkr));
          nkr++;
        end
      end
      if (w[7]) begin
        if (first_ex < 0) first_ex = i;
        last_ex = i;
        nex++;
        chk("ex_no_ld", 128'(w[6]), 128'(0));
        if (w[5]) begin
          chk("ex_addr", 128'(w[17:13]), 128'(nexr));
          nexr++;
        end
      end
      if (w[18]) begin
        if (first_of < 0) first_of = i;
        last_of = i;
        nof++;
      end
      if (w[0]) begin
        chk("pw_addr", 128'(w[12:8]), 128'(npw));
        if (i > 0) chk("pw_lag", 128'(inst_q[i-1][18]), 128'(1));
        else chk("pw_lag", 128'(0), 128'(1));
        npw++;
      end
      if (w[1]) nrd++;
      if (done_q[i]) begin
        ndone++;
        done_i = i;
      end
    end
    chk("n_qwr", 128'(nq), 128'(q));
    chk("n_kwr", 128'(nk), 128'(COL));
    chk("n_ld", 128'(nld), 128'(COL + 1));
    chk("n_kmem_rd", 128'(nkr), 128'(COL));
    chk("n_exec", 128'(nex), 128'(q + 1));
    chk("n_qmem_rd", 128'(nexr), 128'(q));
    chk("n_ofifo", 128'(nof), 128'(q));
    chk("ofifo_contig", 128'(last_of - first_of + 1), 128'(q));
    chk("n_pmem_wr", 128'(npw), 128'(q));
    chk("load_gap", 128'(first_ex - last_ld - 1), 128'(GAP));
    chk("drain_gap", 128'(first_of - last_ex - 1), 128'(DRAIN));
    chk("exec_contig", 128'(last_ex - first_ex + 1), 128'(q + 1));
`ifdef PMEM_READBACK_EN
    chk("n_pmem_rd", 128'(nrd), 128'(q));
`else
    chk("n_pmem_rd", 128'(nrd), 128'(0));
`endif
    chk("n_done", 128'(ndone), 128'(1));
    chk("busy_first", 128'(busy_q[0]), 128'(1));
    if (done_i > 0) begin
      chk("busy_at_done", 128'(busy_q[done_i]), 128'(0));
      chk("busy_before_done", 128'(busy_q[done_i-1]), 128'(1));
    end
  endtask

  // Issue start, stream q+COL beats, then either wait for done or reset mid-EXEC.
  task automatic run_job(input int q, input bit tog, input bit abort_exec);
    int beat, cyc, nd;
    bit rdy, v, got;
    inst_q.delete(); mem_q.delete(); done_q.delete(); busy_q.delete();
    @(posedge clk); #1;
    start = 1'b1; q_len = 6'(q);
    @(posedge clk); #1;
    start = 1'b0; rec = 1'b1;
    beat = 0; cyc = 0;
    while (beat < q + COL && cyc < 400) begin
      v = tog ? ~cyc[0] : 1'b1;
      in_valid = v;
      in_data = beat_data(beat);
      @(negedge clk);
      rdy = in_ready;
      chk("in_ready", 128'(rdy), 128'(1));
      @(posedge clk); #1;
      if (rdy && v) beat++;
      cyc++;
    end
    in_valid = 1'b0;
    if (beat < q + COL) chk("feed_timeout", 128'(beat), 128'(q + COL));
    got = 1'b0; cyc = 0;
    if (abort_exec) begin
      while (!got && cyc < 200) begin
        @(negedge clk);
        if (inst[7]) got = 1'b1;
        cyc++;
      end
      chk("exec_seen", 128'(got), 128'(1));
      @(posedge clk); #1; reset = 1'b1;
      @(posedge clk); #1; reset = 1'b0;
      @(negedge clk);
      chk("rst_inst", 128'(inst), 128'(0));
      chk("rst_busy", 128'(busy), 128'(0));
      chk("rst_ready", 128'(in_ready), 128'(0));
      chk("rst_done", 128'(done), 128'(0));
      nd = 0;
      for (int i = 0; i < 60; i++) begin
        @(negedge clk);
        if (done || inst != 19'd0) nd++;
      end
      chk("rst_quiet", 128'(nd), 128'(0));
      rec = 1'b0;
    end else begin
      while (!got && cyc < 500) begin
        @(negedge clk);
        if (done) got = 1'b1;
        cyc++;
      end
      chk("done_seen", 128'(got), 128'(1));
      @(negedge clk);
      @(negedge clk);
      rec = 1'b0;
      analyze(q);
    end
  endtask

  initial begin
    // Reset then idle: every output stays quiet.
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_inst", 128'(inst), 128'(0));
      chk("idle_mem_in", mem_in, 128'(0));
      chk("idle_ready", 128'(in_ready), 128'(0));
      chk("idle_busy", 128'(busy), 128'(0));
      chk("idle_done", 128'(done), 128'(0));
    end

    run_job(2, 1'b0, 1'b0);
    run_job(3, 1'b1, 1'b0);
    run_job(32, 1'b0, 1'b0);

    // q_len = 0: done pulses next cycle and nothing else happens.
    @(posedge clk); #1;
    start = 1'b1; q_len = 6'd0;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("q0_done", 128'(done), 128'(1));
    chk("q0_busy", 128'(busy), 128'(0));
    chk("q0_inst", 128'(inst), 128'(0));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("q0_after_done", 128'(done), 128'(0));
      chk("q0_after_busy", 128'(busy), 128'(0));
      chk("q0_after_inst", 128'(inst), 128'(0));
    end

    run_job(2, 1'b0, 1'b1);
    run_job(1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/qk_inst_sequencer.md
Name: qk_inst_sequencer

Overview:
- Initiator for the attention core's 19-bit instruction bus and its shared Q/K memory data input; replaces hand-written testbench instruction streams.
- Accepts streamed Q and K vectors over a valid/ready interface and writes them into qmem and kmem.
- Sequences kernel load, execute, drain and output-FIFO-to-psum-memory writeback, then pulses done.

Parameters:
col, 8, MAC array columns (number of K vectors)
bw, 8, element width
pr, 16, elements per Q/K vector
LOAD_GAP, 4, idle cycles between kernel load and execute
DRAIN_CYC, 16, idle cycles between execute and output readout

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
start  input  1  begin a job; sampled only in IDLE
q_len  input  6  number of Q vectors; latched on start; legal range 1..32
in_data  input  pr*bw  Q/K vector stream
in_valid  input  1  in_data valid
in_ready  output  1  sequencer accepts in_data this cycle
inst  output  19  instruction bus to core, registered
mem_in  output  pr*bw  data to core qmem/kmem, registered
busy  output  1  high from the cycle after start until done
done  output  1  one-cycle pulse when job completes

Behaviour:
- Interface decided: single clock clk; reset is synchronous, active-high, named reset.
- Inst fields:
  - [18] ofifo_rd; [17:13] qkmem_add; [12:8] pmem_add.
  - [7] execute; [6] kernel load and K-select.
  - [5] qmem_rd; [4] qmem_wr; [3] kmem_rd; [2] kmem_wr; [1] pmem_rd; [0] pmem_wr.
- Every inst bit not listed as active for a state is 0.
- Reset: state IDLE; inst=0, mem_in=0, in_ready=0, busy=0, done=0; all counters 0. Applies mid-job; the job is abandoned with no done pulse.
- IDLE:
  - start=1 with q_len in 1..32: latch q_len, go WR_Q.
  - start=1 with q_len=0: pulse done next cycle, stay IDLE.
  - start is ignored in all other states.
- WR_Q:
  - in_ready=1 while count<q_len.
  - Each accepted beat: next cycle inst[4]=1, qkmem_add=count, mem_in=in_data.
  - Cycles with no accepted beat drive inst=0; mem_in holds its value.
  - After the q_len-th beat, go WR_K.
- WR_K: same as WR_Q but uses kmem_wr (inst[2]); accepts col beats at addresses 0..col-1, then goes LD_K.
- in_ready is combinational from state and count only, never from in_valid.
- LD_K: col+1 cycles.
  - Cycles 0..col-1: inst[3]=1, qkmem_add=cycle.
  - inst[6]=1 on all col+1 cycles.
- GAP: LOAD_GAP cycles, inst=0.
- EXEC: q_len+1 cycles.
  - Cycles 0..q_len-1: inst[5]=1, qkmem_add=cycle.
  - inst[7]=1 on all q_len+1 cycles; inst[6]=0.
- DRAIN: DRAIN_CYC cycles, inst=0.
- OUT: q_len+1 cycles.
  - Cycles 0..q_len-1: inst[18]=1.
  - Cycles 1..q_len: inst[0]=1, pmem_add=cycle-1. pmem_wr lags ofifo_rd by exactly one cycle.
- DONE: one cycle; done=1, busy=0 next cycle; return IDLE.
- Address fields are 5 bits wide; q_len=32 uses addresses 0..31 with no wrap.
- A beat accepted on the final WR_Q cycle must not also be counted toward WR_K.

Optional Feature:
- Macro PMEM_READBACK_EN.
- Defined: after OUT, state RDBK runs q_len cycles with inst[1]=1 and pmem_add=cycle, so core out presents results 0..q_len-1 one cycle later; then DONE.
- Undefined: OUT goes directly to DONE; inst[1] is never asserted.

Test Plan:
- Reset then idle 5 cycles -> inst=0, mem_in=0, in_ready=0, busy=0, done=0 throughout.
- start with q_len=2, in_valid held 1, data 0x11..,0x22.. then eight K words -> two qmem writes at addresses 0,1, eight kmem writes at 0..7; inst[6] high 9 cycles; inst[7] high 3 cycles; ofifo_rd high 2 cycles; pmem_wr at addresses 0,1 one cycle later; done pulses once.
- q_len=3 with in_valid toggled 1,0,1,0 -> in_ready stays 1; writes occur only on accepted beats, addresses 0,1,2 contiguous; no write bit on stall cycles.
- q_len=32 -> qmem addresses 0..31; EXEC 33 cycles; pmem_add reaches 31; no address wrap.
- start with q_len=0 -> done pulses next cycle; no inst bit ever set; busy stays 0.
- reset asserted during EXEC -> next cycle inst=0, busy=0, state IDLE; no done pulse; a new start with q_len=1 completes normally.
